// File: rtl/mole_judge.sv
// Two-hole whack-a-mole judge: lights one hole per round, grades debounced presses, keeps BCD score and misses.
// Optional feature macro MOLE_SPEEDUP_EN shrinks the show window by one tick every 10 hits (floor 4).
module mole_judge #(
    parameter int SHOW_TICKS = 20,
    parameter int ROUNDS     = 30
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] button_d,
    input  logic       start,
    output logic [1:0] mole_led,
    output logic       hit,
    output logic [7:0] score,
    output logic [3:0] miss_cnt,
    output logic       game_over
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW,
        ST_HIT,
        ST_MISS,
        ST_GAP,
        ST_OVER
    } state_t;

    localparam logic [7:0] SHOW_TICKS_W = 8'(SHOW_TICKS);
    localparam logic [7:0] LAST_ROUND   = 8'(ROUNDS - 1);
    localparam logic [3:0] LFSR_SEED    = 4'b1001;

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] prev_button_reg;
    logic       prev_start_reg;
    logic [3:0] lfsr_reg;
    logic [7:0] timer_reg;
    logic [7:0] round_reg;
    logic [7:0] score_reg;
    logic [3:0] miss_reg;

    logic [1:0] button_rise;
    logic       start_rise;
    logic [1:0] lit_onehot;
    logic       correct_rise;
    logic       wrong_rise;
    logic       timeout;
    logic       game_start;
    logic       enter_hit;
    logic       enter_miss;
    logic [7:0] window;
    logic [7:0] score_inc;
    logic [3:0] lfsr_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rise
            assign button_rise[gi] = button_d[gi] & ~prev_button_reg[gi];
        end
    endgenerate

    assign start_rise   = start & ~prev_start_reg;
    assign lit_onehot   = lfsr_reg[0] ? 2'b10 : 2'b01;
    // A double press never equals the one-hot lit pattern, so it grades as wrong.
    assign correct_rise = (button_rise == lit_onehot);
    assign wrong_rise   = (button_rise != 2'b00) && !correct_rise;
    assign timeout      = (timer_reg == (window - 8'd1));
    assign game_start   = ((state_reg == ST_IDLE) || (state_reg == ST_OVER)) && start_rise;
    assign enter_hit    = (state_reg == ST_SHOW) && (state_next == ST_HIT);
    assign enter_miss   = (state_reg == ST_SHOW) && (state_next == ST_MISS);
    assign lfsr_next    = {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};

    // Packed BCD increment that holds at 99.
    always_comb begin
        score_inc = score_reg;
        if (score_reg != 8'h99) begin
            if (score_reg[3:0] == 4'd9) begin
                score_inc = {score_reg[7:4] + 4'd1, 4'd0};
            end else begin
                score_inc = {score_reg[7:4], score_reg[3:0] + 4'd1};
            end
        end
    end

`ifdef MOLE_SPEEDUP_EN
    localparam logic [7:0] MIN_WINDOW = 8'd4;
    logic [7:0] window_reg;

    // Units digit wrapping to zero marks every 10th hit of the game.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            window_reg <= SHOW_TICKS_W;
        end else if (game_start) begin
            window_reg <= SHOW_TICKS_W;
        end else if (enter_hit && (score_inc[3:0] == 4'd0) && (window_reg > MIN_WINDOW)) begin
            window_reg <= window_reg - 8'd1;
        end
    end

    assign window = window_reg;
`else
    assign window = SHOW_TICKS_W;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_rise) state_next = ST_SHOW;
            end
            ST_SHOW: begin
                if (correct_rise) begin
                    state_next = ST_HIT;
                end else if (wrong_rise || timeout) begin
                    state_next = ST_MISS;
                end
            end
            ST_HIT:  state_next = ST_GAP;
            ST_MISS: state_next = ST_GAP;
            ST_GAP: begin
                if (round_reg == LAST_ROUND) begin
                    state_next = ST_OVER;
                end else begin
                    state_next = ST_SHOW;
                end
            end
            ST_OVER: begin
                if (start_rise) state_next = ST_SHOW;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mole_led  = 2'b00;
        hit       = 1'b0;
        game_over = 1'b0;
        case (state_reg)
            ST_SHOW: mole_led  = lit_onehot;
            ST_HIT:  hit       = 1'b1;
            ST_OVER: game_over = 1'b1;
            default: ;
        endcase
    end

    // Round bookkeeping; edge-detect history updates every cycle regardless of state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prev_button_reg <= 2'b00;
            prev_start_reg  <= 1'b0;
            lfsr_reg        <= LFSR_SEED;
            timer_reg       <= 8'd0;
            round_reg       <= 8'd0;
            score_reg       <= 8'h00;
            miss_reg        <= 4'd0;
        end else begin
            prev_button_reg <= button_d;
            prev_start_reg  <= start;
            if (game_start) begin
                timer_reg <= 8'd0;
                round_reg <= 8'd0;
                score_reg <= 8'h00;
                miss_reg  <= 4'd0;
            end
            if (state_reg == ST_SHOW) begin
                timer_reg <= timer_reg + 8'd1;
            end
            if (enter_hit) begin
                score_reg <= score_inc;
            end
            if (enter_miss && (miss_reg != 4'hF)) begin
                miss_reg <= miss_reg + 4'd1;
            end
            if (state_reg == ST_GAP) begin
                lfsr_reg  <= lfsr_next;
                round_reg <= round_reg + 8'd1;
                timer_reg <= 8'd0;
            end
        end
    end

    assign score    = score_reg;
    assign miss_cnt = miss_reg;

endmodule

// File: tb/tb_mole_judge.sv
// Randomized scoreboard bench for mole_judge: a per-round game model predicts each round's outcome,
// a monitor checks the DUT's show length, hit pulse, score, misses and game_over as rounds complete.
module tb_mole_judge;

    localparam int SHOW_TICKS = 6;
    localparam int ROUNDS     = 110;
    localparam int A_NONE     = 0;
    localparam int A_LIT      = 1;
    localparam int A_WRONG    = 2;
    localparam int A_BOTH     = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] button_d = 2'b00;
    logic       start = 1'b0;
    logic [1:0] mole_led;
    logic       hit;
    logic [7:0] score;
    logic [3:0] miss_cnt;
    logic       game_over;

    mole_judge #(
        .SHOW_TICKS(SHOW_TICKS),
        .ROUNDS    (ROUNDS)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .button_d (button_d),
        .start    (start),
        .mole_led (mole_led),
        .hit      (hit),
        .score    (score),
        .miss_cnt (miss_cnt),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] led;
        logic       hit;
        int         len;
        logic [7:0] score;
        logic [3:0] miss;
        logic       over;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         pushed   = 0;
    int         mon_done = 0;
    bit         mon_en   = 1'b1;

    logic [3:0] m_lfsr;
    int         m_score;
    int         m_miss;
    logic [1:0] last_led;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lfsr_step(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    function automatic int cur_win();
`ifdef MOLE_SPEEDUP_EN
        int w;
        w = SHOW_TICKS - m_score / 10;
        return (w < 4) ? 4 : w;
`else
        return SHOW_TICKS;
`endif
    endfunction

    task automatic plan_round(input int game, input bit forced_none,
                              output int act, output int k, output bit hold);
        int r;
        int w;
        w    = cur_win();
        hold = 1'b0;
        k    = $urandom_range(0, w - 1);
        r    = $urandom_range(0, 9);
        if (forced_none) begin
            act = A_NONE;
        end else if (game == 0) begin
            act = A_LIT;
        end else begin
            case (r)
                0, 1, 2, 3: act = A_LIT;
                4, 5:       act = A_NONE;
                6:          act = A_WRONG;
                7:          act = A_BOTH;
                8: begin
                    act = A_LIT;
                    k   = w - 1;
                end
                default: begin
                    act  = A_LIT;
                    hold = 1'b1;
                end
            endcase
        end
    endtask

    // Predict one round from the game rules and queue it for the monitor.
    task automatic push_round(input int act, input int k, input bit last);
        exp_t e;
        int   w;
        w        = cur_win();
        e.led    = m_lfsr[0] ? 2'b10 : 2'b01;
        last_led = e.led;
        if (act == A_LIT) begin
            e.hit   = 1'b1;
            e.len   = k + 1;
            m_score = (m_score < 99) ? m_score + 1 : 99;
        end else begin
            e.hit  = 1'b0;
            e.len  = (act == A_NONE) ? w : k + 1;
            m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        end
        e.score = to_bcd(m_score);
        e.miss  = 4'(m_miss);
        e.over  = last;
        m_lfsr  = lfsr_step(m_lfsr);
        sb_q.push_back(e);
        pushed++;
    endtask

    task automatic play_game(input int game);
        int         act;
        int         k;
        int         n;
        int         c;
        int         hold_state;
        bit         hold;
        bit         show_noise;
        bit         gap_noise;
        logic [1:0] bits;
        m_score    = 0;
        m_miss     = 0;
        hold_state = 0;
        plan_round(game, 1'b0, act, k, hold);
        push_round(act, k, ROUNDS == 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int r = 0; r < ROUNDS; r++) begin
            n = 0;
            @(negedge clk);
            while (mole_led == 2'b00 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (mole_led == 2'b00) begin
                checks++;
                errors++;
                $display("FAIL mole_wait actual=00 required=lit_hole game=%0d round=%0d", game, r);
                button_d = 2'b00;
                return;
            end
            case (act)
                A_LIT:   bits = last_led;
                A_WRONG: bits = ~last_led & 2'b11;
                A_BOTH:  bits = 2'b11;
                default: bits = 2'b00;
            endcase
            show_noise = ($urandom_range(0, 3) == 0);
            c = 0;
            while (c < 300) begin
                if (mole_led == 2'b00) begin
                    start = 1'b0;
                    if (act != A_NONE && !hold) button_d = button_d & ~bits;
                    break;
                end
                start = (c == 0) && show_noise;
                if (act != A_NONE && c == k) button_d = button_d | bits;
                @(negedge clk);
                c++;
            end
            if (hold_state == 1) begin
                button_d   = 2'b00;
                hold_state = 0;
            end else if (hold) begin
                hold_state = 1;
            end
            gap_noise = (hold_state == 0) && ($urandom_range(0, 2) == 0);
            if (r < ROUNDS - 1) begin
                plan_round(game, hold_state == 1, act, k, hold);
                push_round(act, k, (r + 1) == (ROUNDS - 1));
            end
            if (gap_noise) begin
                button_d = 2'($urandom_range(1, 3));
                start    = 1'($urandom_range(0, 1));
                @(negedge clk);
                button_d = 2'b00;
                start    = 1'b0;
            end
        end
        button_d = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mon_done != pushed && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", mon_done, pushed);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: one scoreboard entry per lit mole.
    initial begin
        bit   in_show;
        int   len;
        exp_t e;
        in_show = 1'b0;
        forever begin
            if (!in_show) begin
                @(negedge clk);
                if (!mon_en || mole_led == 2'b00) continue;
            end
            in_show = 1'b0;
            if (sb_q.size() == 0) begin
                check("unexpected_show", int'(mole_led), 0);
                len = 0;
                while (mole_led != 2'b00 && len < 300) begin
                    @(negedge clk);
                    len++;
                end
                continue;
            end
            e = sb_q.pop_front();
            check("mole_led", int'(mole_led), int'(e.led));
            len = 1;
            while (len < 300) begin
                @(negedge clk);
                if (mole_led == 2'b00) break;
                len++;
            end
            check("show_len", len, e.len);
            check("hit", int'(hit), int'(e.hit));
            @(negedge clk);
            check("gap_score", int'(score), int'(e.score));
            check("gap_miss", int'(miss_cnt), int'(e.miss));
            check("gap_led", int'(mole_led), 0);
            check("gap_hit", int'(hit), 0);
            @(negedge clk);
            check("game_over", int'(game_over), int'(e.over));
            $display("round led=%b hit=%0d len=%0d score=%h miss=%0d over=%0d",
                     e.led, e.hit, e.len, e.score, e.miss, e.over);
            mon_done++;
            if (mole_led != 2'b00) in_show = 1'b1;
        end
    end

    task automatic wait_show(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (mole_led == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(mole_led != 2'b00), 1);
    endtask

    initial begin
        logic [1:0] exp_led;
        #12;
        check("rst_led", int'(mole_led), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_score", int'(score), 0);
        check("rst_miss", int'(miss_cnt), 0);
        check("rst_over", int'(game_over), 0);
        @(negedge clk);
        clr    = 1'b1;
        m_lfsr = 4'b1001;

        for (int g = 0; g < 3; g++) begin
            play_game(g);
            drain();
        end

        // Directly observed game: one hit, then reset in the middle of the next show.
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_show("restart_show");
        exp_led = m_lfsr[0] ? 2'b10 : 2'b01;
        check("restart_led", int'(mole_led), int'(exp_led));
        check("restart_score", int'(score), 0);
        check("restart_miss", int'(miss_cnt), 0);
        check("restart_over", int'(game_over), 0);
        button_d = mole_led;
        @(negedge clk);
        check("direct_hit", int'(hit), 1);
        check("direct_score", int'(score), 8'h01);
        check("direct_hit_led", int'(mole_led), 0);
        button_d = 2'b00;
        @(negedge clk);
        check("direct_gap_hit", int'(hit), 0);
        check("direct_gap_led", int'(mole_led), 0);
        m_lfsr  = lfsr_step(m_lfsr);
        exp_led = m_lfsr[0] ? 2'b10 : 2'b01;
        @(negedge clk);
        check("direct_next_led", int'(mole_led), int'(exp_led));
        #2 clr = 1'b0;
        #1;
        check("clr_led", int'(mole_led), 0);
        check("clr_hit", int'(hit), 0);
        check("clr_score", int'(score), 0);
        check("clr_miss", int'(miss_cnt), 0);
        check("clr_over", int'(game_over), 0);
        @(negedge clk);
        @(negedge clk);
        clr    = 1'b1;
        m_lfsr = 4'b1001;
        repeat (3) @(negedge clk);
        check("idle_led", int'(mole_led), 0);
        check("idle_over", int'(game_over), 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_show("post_clr_show");
        check("post_clr_led", int'(mole_led), 2'b10);
        check("post_clr_score", int'(score), 0);
        check("post_clr_miss", int'(miss_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
